// File: rtl/tx_write_arbiter_pkg.sv
// Shared definitions for the transmit-FIFO write arbiter: sequencer state
// encodings, the default word width shared with the FIFO and transmitter,
// and a helper that sizes requester index fields.
package tx_write_arbiter_pkg;

  // Default transmitted word width, common to FIFO, arbiter and transmitter.
  localparam int TX_DATA_W = 8;

  // Two-state write sequencer.
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Bits needed to index n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_write_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter. The slave modport is the
// arbiter's view; the master modport is the environment (producers plus the
// FIFO full flag).
interface tx_write_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   fifo_full;
  logic                   fifo_we;
  logic [DATA_W-1:0]      fifo_data;
  logic                   busy;

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, fifo_we, fifo_data, busy
  );

  modport master (
    output req, req_data, fifo_full,
    input  gnt, fifo_we, fifo_data, busy
  );
endinterface

// File: rtl/tx_write_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: picks the first set request
// scanning upward from (last+1) mod NREQ, wrapping around.
module rr_pick
  import tx_write_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_pos;

  // Scan candidates in priority order starting just after the last winner.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = (int'(i_last) + k) % NREQ;
      if (!o_any && i_req[IDX_W'(w_pos)]) begin
        o_onehot[IDX_W'(w_pos)] = 1'b1;
        o_idx                   = IDX_W'(w_pos);
        o_any                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_write_arbiter.sv
// Round-robin arbiter sharing the transmit FIFO write port among NREQ byte
// producers. A two-state sequencer (ARB -> HOLD -> ARB) registers one word
// per grant, so each accepted word is written exactly once and acknowledged
// with a one-cycle one-hot gnt. Optional per-requester saturating grant
// counters are built when TX_ARB_STATS_EN is defined.
module tx_write_arbiter
  import tx_write_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = TX_DATA_W
`ifdef TX_ARB_STATS_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  tx_write_arbiter_if.slave      bus
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]  grant_cnt
`endif
);

  localparam int IDX_W = idx_w(NREQ);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_last, w_last_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic              r_fifo_we, w_we_nxt;
  logic [DATA_W-1:0] r_fifo_data, w_data_nxt;

  logic [NREQ-1:0]   w_onehot;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // Sequencer state register; reset returns to ARB.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) r_state <= ST_ARB;
    else     r_state <= w_state_nxt;
  end

  // Next state and next register values: grant only in ARB with a free FIFO.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gnt_nxt   = '0;
    w_we_nxt    = 1'b0;
    w_data_nxt  = r_fifo_data;
    case (r_state)
      ST_ARB: begin
        if (w_any && !bus.fifo_full) begin
          w_gnt_nxt   = w_onehot;
          w_we_nxt    = 1'b1;
          w_data_nxt  = bus.req_data[int'(w_idx)*DATA_W +: DATA_W];
          w_last_nxt  = w_idx;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // Registered FIFO write port, acknowledge and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= IDX_W'(NREQ - 1);
      r_gnt       <= '0;
      r_fifo_we   <= 1'b0;
      r_fifo_data <= '0;
    end else begin
      r_last      <= w_last_nxt;
      r_gnt       <= w_gnt_nxt;
      r_fifo_we   <= w_we_nxt;
      r_fifo_data <= w_data_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.fifo_we   = r_fifo_we;
  assign bus.fifo_data = r_fifo_data;
  assign bus.busy      = (r_state == ST_HOLD);

`ifdef TX_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    // Saturating count of grants registered for requester g.
    always_ff @(posedge clk) begin
      if (rst)
        r_cnt[g] <= '0;
      else if (w_gnt_nxt[g] && (r_cnt[g] != {CNT_W{1'b1}}))
        r_cnt[g] <= r_cnt[g] + 1'b1;
    end
    assign grant_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`endif

endmodule
